// File: rtl/physics_pkg.sv
// Shared types and constants for the game physics path.
package physics_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } plat_t;

    // One step of the 16-bit Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/platform_scheduler_if.sv
// Frame/doodle inputs, renderer read port and physics outputs of the scheduler.
interface platform_scheduler_if #(
    parameter int unsigned NUM_PLAT = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_PLAT);

    logic             frame_tick;
    logic [9:0]       doodle_x;
    logic [9:0]       doodle_y;
    logic [9:0]       doodle_s;
    logic             doodle_falling;
    logic [IDX_W-1:0] rd_idx;
    logic [9:0]       rd_x;
    logic [9:0]       rd_y;
    logic             bounce;
    logic [IDX_W-1:0] land_idx;
    logic [9:0]       scroll_amt;
    logic             busy;
    logic [15:0]      score;

    modport master (
        output frame_tick, doodle_x, doodle_y, doodle_s, doodle_falling, rd_idx,
        input  rd_x, rd_y, bounce, land_idx, scroll_amt, busy, score
    );

    modport slave (
        input  frame_tick, doodle_x, doodle_y, doodle_s, doodle_falling, rd_idx,
        output rd_x, rd_y, bounce, land_idx, scroll_amt, busy, score
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with seed on reset.
module lfsr16
    import physics_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Step once per clock.
    always_ff @(posedge Clk) begin
        if (Reset) q <= seed;
        else       q <= lfsr_step(q);
    end

endmodule

// File: rtl/platform_scheduler.sv
// Per-frame platform scroll/recycle/landing sequencer with renderer read port.
module platform_scheduler
    import physics_pkg::*;
#(
    parameter int unsigned NUM_PLAT    = 8,
    parameter int unsigned SCROLL_LINE = 200,
    parameter int unsigned PLAT_HALF_W = 16,
    parameter int unsigned LAND_WIN    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          Clk,
    input  logic          Reset,
    platform_scheduler_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(NUM_PLAT);
    localparam int unsigned Y_SPAN = SCREEN_Y_MAX + 1;
    localparam int unsigned X_BASE = 64;

    sched_state_t     state, state_nx;
    plat_t            plats [NUM_PLAT];
    logic [IDX_W-1:0] slot_idx, land_tmp, land_q;
    logic             hit_q, bounce_q, busy_q;
    logic             bounce_d, busy_d;
    logic [9:0]       lat_x, lat_y, lat_s;
    logic             lat_fall;
    logic [9:0]       scroll_q, rd_x_q, rd_y_q;
    logic [15:0]      score_q, lfsr_q;
    logic [16:0]      score_sum;
    logic             last_c, hit_now_c;
    plat_t            cur, wr;
    logic [10:0]      y_sum, foot;
    logic [9:0]       adx;
    logic             unused_lfsr;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:9];

    // Scroll/recycle of the current slot and its landing test against the latched doodle.
    always_comb begin
        cur   = plats[slot_idx];
        wr    = cur;
        y_sum = 11'(cur.y) + 11'(scroll_q);
        if (y_sum > 11'(SCREEN_Y_MAX)) begin
            wr.y = 10'(y_sum - 11'(Y_SPAN));
            wr.x = 10'(X_BASE) + 10'(lfsr_q[8:0]);
        end else begin
            wr.y = y_sum[9:0];
        end
        foot      = 11'(lat_y) + 11'(lat_s);
        adx       = (lat_x >= wr.x) ? (lat_x - wr.x) : (wr.x - lat_x);
        hit_now_c = lat_fall
                  && (foot >= 11'(wr.y))
                  && (foot <= 11'(wr.y) + 11'(LAND_WIN))
                  && (11'(adx) <= 11'(PLAT_HALF_W) + 11'(lat_s));
        last_c    = (slot_idx == IDX_W'(NUM_PLAT - 1));
        score_sum = 17'(score_q) + 17'(scroll_q);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.frame_tick) state_nx = SCAN;
            SCAN:    if (last_c)         state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; bounce lands in the DONE cycle, busy covers SCAN and DONE.
    always_comb begin
        busy_d   = 1'b0;
        bounce_d = 1'b0;
        if (state_nx != IDLE)                            busy_d   = 1'b1;
        if ((state == SCAN) && last_c && (hit_q || hit_now_c)) bounce_d = 1'b1;
    end

    // Frame datapath: doodle latch, slot table update, landing capture, score.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(NUM_PLAT); i++) begin
                plats[i].x <= 10'(X_BASE + 64 * i);
                plats[i].y <= 10'(60 * i);
            end
            slot_idx <= '0;
            land_tmp <= '0;
            land_q   <= '0;
            hit_q    <= 1'b0;
            lat_x    <= '0;
            lat_y    <= '0;
            lat_s    <= '0;
            lat_fall <= 1'b0;
            scroll_q <= '0;
            score_q  <= '0;
            bounce_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            bounce_q <= bounce_d;
            busy_q   <= busy_d;
            case (state)
                IDLE: if (bus.frame_tick) begin
                    lat_x    <= bus.doodle_x;
                    lat_y    <= bus.doodle_y;
                    lat_s    <= bus.doodle_s;
                    lat_fall <= bus.doodle_falling;
                    scroll_q <= (bus.doodle_y < 10'(SCROLL_LINE))
                              ? 10'(SCROLL_LINE) - bus.doodle_y : 10'd0;
                    slot_idx <= '0;
                    hit_q    <= 1'b0;
                end
                SCAN: begin
                    plats[slot_idx] <= wr;
                    slot_idx        <= slot_idx + IDX_W'(1);
                    if (hit_now_c && !hit_q) begin
                        hit_q    <= 1'b1;
                        land_tmp <= slot_idx;
                    end
                    if (last_c) begin
                        if (hit_q)          land_q <= land_tmp;
                        else if (hit_now_c) land_q <= slot_idx;
                        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered renderer read port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else begin
            rd_x_q <= plats[bus.rd_idx].x;
            rd_y_q <= plats[bus.rd_idx].y;
        end
    end

    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;
    assign bus.bounce     = bounce_q;
    assign bus.land_idx   = land_q;
    assign bus.scroll_amt = scroll_q;
    assign bus.busy       = busy_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler with a per-frame expectation queue.
module tb_platform_scheduler;

    localparam int NP = 8;

    typedef struct {
        bit bounce;
        int land;
        int scroll;
        int score;
    } exp_t;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;
    exp_t sb [$];

    int   mx [NP];
    int   my [NP];
    bit   mx_known [NP];
    int   m_score;
    int   m_land;

    platform_scheduler_if #(.NUM_PLAT(NP)) bus ();

    platform_scheduler #(
        .NUM_PLAT    (NP),
        .SCROLL_LINE (200),
        .PLAT_HALF_W (16),
        .LAND_WIN    (3),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mx[i] = 64 + 64 * i;
            my[i] = 60 * i;
            mx_known[i] = 1'b1;
        end
        m_score = 0;
        m_land  = 0;
    endtask

    // Reference frame: scroll, recycle, first-hit landing, saturating score.
    task automatic model_frame(input int dx, input int dy, input int ds, input bit fall, output exp_t e);
        int  scr, ny, foot, adx;
        bit  hit;
        scr  = (dy < 200) ? 200 - dy : 0;
        hit  = 1'b0;
        foot = dy + ds;
        e.land = m_land;
        for (int i = 0; i < NP; i++) begin
            ny = my[i] + scr;
            if (ny > 479) begin
                ny = ny - 480;
                mx_known[i] = 1'b0;
            end
            my[i] = ny;
            if (mx_known[i]) begin
                adx = (dx > mx[i]) ? dx - mx[i] : mx[i] - dx;
                if (!hit && fall && foot >= ny && foot <= ny + 3 && adx <= 16 + ds) begin
                    hit    = 1'b1;
                    e.land = i;
                end
            end
        end
        m_land   = e.land;
        m_score  = (m_score + scr > 65535) ? 65535 : m_score + scr;
        e.bounce = hit;
        e.scroll = scr;
        e.score  = m_score;
    endtask

    // Full frame from an idle negedge; optional ignored second tick at T+extra_at.
    task automatic run_frame(input int dx, input int dy, input int ds, input bit fall, input int extra_at);
        exp_t e, got;
        bus.doodle_x       = 10'(dx);
        bus.doodle_y       = 10'(dy);
        bus.doodle_s       = 10'(ds);
        bus.doodle_falling = fall;
        bus.frame_tick     = 1'b1;
        model_frame(dx, dy, ds, fall, e);
        sb.push_back(e);
        for (int k = 1; k <= NP; k++) begin
            @(negedge Clk);
            bus.frame_tick = (k == extra_at);
            if (k == extra_at) bus.doodle_y = 10'd0;
            chk("busy_scan", 32'(bus.busy), 32'd1);
            chk("bounce_scan", 32'(bus.bounce), 32'd0);
            if (k == 1) chk("scroll_amt", 32'(bus.scroll_amt), 32'(e.scroll));
        end
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        got = sb.pop_front();
        chk("bounce_done", 32'(bus.bounce), 32'(got.bounce));
        chk("land_idx", 32'(bus.land_idx), 32'(got.land));
        chk("score", 32'(bus.score), 32'(got.score));
        chk("busy_done", 32'(bus.busy), 32'd1);
        chk("scroll_hold", 32'(bus.scroll_amt), 32'(got.scroll));
        @(negedge Clk);
        chk("busy_fall", 32'(bus.busy), 32'd0);
        chk("bounce_fall", 32'(bus.bounce), 32'd0);
    endtask

    task automatic read_all();
        chk("busy_before_read", 32'(bus.busy), 32'd0);
        for (int i = 0; i < NP; i++) begin
            bus.rd_idx = 3'(i);
            @(negedge Clk);
            chk($sformatf("rd_y[%0d]", i), 32'(bus.rd_y), 32'(my[i]));
            if (mx_known[i]) begin
                chk($sformatf("rd_x[%0d]", i), 32'(bus.rd_x), 32'(mx[i]));
            end else begin
                chk($sformatf("rd_x_range[%0d]", i),
                    32'(bus.rd_x >= 10'd64 && bus.rd_x <= 10'd575), 32'd1);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.doodle_x = '0;
        bus.doodle_y = '0;
        bus.doodle_s = '0;
        bus.doodle_falling = 1'b0;
        bus.rd_idx = '0;
        model_reset();

        repeat (3) @(negedge Clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bounce", 32'(bus.bounce), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_scroll", 32'(bus.scroll_amt), 32'd0);
        chk("rst_land", 32'(bus.land_idx), 32'd0);
        chk("rst_rd_x", 32'(bus.rd_x), 32'd0);
        chk("rst_rd_y", 32'(bus.rd_y), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        read_all();

        // Landing against slot 4 (320,240) with doodle at or below the scroll line, so no scroll.
        run_frame(320, 228, 12, 1'b1, 0);
        run_frame(320, 228, 12, 1'b0, 0);
        run_frame(348, 231, 12, 1'b1, 0);   // foot at top+LAND_WIN, |dx| at limit
        run_frame(349, 231, 12, 1'b1, 0);   // |dx| one past limit
        run_frame(320, 232, 12, 1'b1, 0);   // foot one past window

        // Scroll 50 then 100, including recycles of the lowest slots.
        run_frame(100, 150, 10, 1'b0, 0);
        read_all();
        run_frame(100, 100, 10, 1'b0, 0);
        read_all();

        // Landing on slot 2 with a second tick during SCAN that must be dropped.
        run_frame(192, 258, 12, 1'b1, 4);
        repeat (3) begin
            @(negedge Clk);
            chk("no_requeue_busy", 32'(bus.busy), 32'd0);
            chk("no_requeue_bounce", 32'(bus.bounce), 32'd0);
        end
        read_all();

        // Reset mid-SCAN aborts the frame and restores the reset layout.
        bus.doodle_y = 10'd150;
        bus.doodle_falling = 1'b0;
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_bounce", 32'(bus.bounce), 32'd0);
        chk("midrst_score", 32'(bus.score), 32'd0);
        chk("midrst_scroll", 32'(bus.scroll_amt), 32'd0);
        Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        chk("postrst_bounce", 32'(bus.bounce), 32'd0);
        read_all();

        // Drive the score towards the top and into saturation.
        for (int f = 0; f < 327; f++) run_frame(300, 0, 8, 1'b0, 0);
        run_frame(300, 100, 8, 1'b0, 0);
        chk("score_near_max", 32'(bus.score), 32'd65500);
        run_frame(300, 150, 8, 1'b0, 0);
        chk("score_sat", 32'(bus.score), 32'h0000FFFF);
        run_frame(300, 0, 8, 1'b0, 0);
        chk("score_sat_hold", 32'(bus.score), 32'h0000FFFF);
        read_all();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/platform_scheduler.md
# platform_scheduler

Per-frame sequencer for the platform field in the game physics path. On each frame tick it latches the doodle position, scrolls all platforms down when the doodle climbs above the scroll line, and recycles platforms that fall off-screen to random X positions at the top. It checks for a landing against each slot and issues a single bounce pulse to the doodle physics. It also provides a registered read port for the platform renderer and a running height score.

## Interface

Parameters:
- NUM_PLAT, 8: number of platform slots; must be a power of 2, 2..16.
- SCROLL_LINE, 200: doodle Y above which the field scrolls.
- PLAT_HALF_W, 16: platform half width in pixels.
- LAND_WIN, 3: landing tolerance in pixels below the platform top.
- LFSR_SEED, 16'hACE1: non-zero seed for the X randomiser.

Ports:
- Clk, input, 1: the only clock.
- Reset, input, 1: synchronous, active-high.
- frame_tick, input, 1: one-Clk pulse per video frame.
- doodle_x / doodle_y / doodle_s, input, 10 each: doodle centre and size. Sampled on an accepted frame_tick.
- doodle_falling, input, 1: doodle Y motion is positive (moving down). Sampled with the position.
- rd_idx, input, $clog2(NUM_PLAT): renderer slot select.
- rd_x / rd_y, output, 10 each: slot rd_idx position, registered.
- bounce, output, 1: one-Clk landing pulse.
- land_idx, output, $clog2(NUM_PLAT): slot that produced the last bounce.
- scroll_amt, output, 10: scroll applied in the current or last frame.
- busy, output, 1: high while a frame update is in progress.
- score, output, 16: cumulative scroll total, saturating.

## Operation

- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On frame_tick, latch doodle_x, doodle_y, doodle_s and doodle_falling.
  - Set scroll_amt to SCROLL_LINE − doodle_y when doodle_y < SCROLL_LINE, otherwise 0.
  - Clear slot index i to 0 and the hit flag, then go to SCAN.
- SCAN: process one slot per cycle, i = 0..NUM_PLAT−1.
  - Compute y_new = y[i] + scroll_amt using 11-bit arithmetic.
  - If y_new > 479 (recycle), write y[i] = y_new − 480 and x[i] = 64 + lfsr[8:0]; the resulting X range is 64..575.
  - Otherwise write y[i] = y_new[9:0].
  - Landing check uses the written (post-scroll) values.
    - Conditions: doodle_falling, AND doodle_y + doodle_s within [y, y + LAND_WIN], AND |doodle_x − x| ≤ PLAT_HALF_W + doodle_s.
    - On the first hit, set the hit flag and capture land_idx = i. Later hits in the same frame are ignored, so the lowest index wins.
  - After i = NUM_PLAT−1, go to DONE.
- DONE:
  - Pulse bounce if the hit flag is set.
  - Update score += scroll_amt, saturating at 16'hFFFF.
  - Return to IDLE.
- frame_tick while busy is ignored; it is not queued.
- The LFSR is a 16-bit Galois LFSR with mask 16'hB400, stepped every Clk.
- Read port: rd_x and rd_y are registered from slot rd_idx, returning stored values. During SCAN the renderer may see a mix of old and new slot positions; it must read only while busy = 0.
- Reset state:
  - y[i] = 60·i and x[i] = 64 + 64·i (so 64..512 for 8 slots).
  - FSM in IDLE.
  - scroll_amt = 0, score = 0, bounce = 0, land_idx = 0, busy = 0.
  - rd_x = rd_y = 0 until the first post-reset read cycle.
  - LFSR = LFSR_SEED.
- Reset asserted mid-SCAN aborts the frame and restores the full reset state on the next edge.

## Timing

- frame_tick at cycle T sets busy = 1 from T+1.
- SCAN occupies T+1 .. T+NUM_PLAT, and DONE is at T+NUM_PLAT+1.
- bounce is high for exactly cycle T+NUM_PLAT+1 (T+9 for NUM_PLAT = 8). score is updated on the same edge.
- busy falls at T+NUM_PLAT+2. The earliest next accepted tick is that cycle.
- Read latency is 1 cycle: rd_idx at cycle C gives data at C+1.
- scroll_amt is valid from T+1 and holds until the next accepted tick.

## Structure

- Shared physics_pkg contains:
  - sched_state_t enum.
  - SCREEN_X_MAX = 639 and SCREEN_Y_MAX = 479.
  - plat_t packed struct {x[9:0], y[9:0]}.
- Slot storage is a plat_t array inside the block.
- One sub-module, lfsr16 (ports Clk, Reset, seed, q[15:0]), reusable elsewhere in the game.

## Test plan

- Reset, then read all slots → y = 0,60,…,420; x = 64,128,…,512; busy = 0; score = 0.
- Tick with doodle_y = 150 → scroll_amt = 50; slot 7 y 420→470; slot 0 y = 50; score = 50; bounce at T+9; busy falls at T+10.
- Tick with doodle_y = 100 → scroll_amt = 100; slot 7 recycles to y = 40 with x in 64..575; other slots shifted by 100.
- Falling doodle at x = 256, y + s = 181 (y = 169, s = 12) against slot 3 at (256, 180) with no scroll → bounce at T+9, land_idx = 3. The same stimulus with doodle_falling = 0 gives no bounce.
- Second frame_tick at T+4 → ignored; single DONE, a single bounce at most, busy timing unchanged.
- Reset asserted at T+5 mid-SCAN → next cycle shows full reset layout, busy = 0, no bounce. Also preload score = 16'hFFF0, tick with scroll 50 → score = 16'hFFFF.
